wb_pl_mem_slave: RTL and testbench

- Pipelined Wishbone responder: single-port word memory on the slave side of the pipelined bus used by the instruction fetch unit and the data port.
- Serves the fetch stream at one word per cycle when WAIT_STATES=0.
- Wait states are inserted with `bus_stall` when WAIT_STATES>0.
- Byte-lane writes are supported for the data port.

---
 rtl/wb_pl_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_wb_pl_mem_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pl_mem_slave.sv
// Pipelined Wishbone word-memory responder with byte lanes and optional wait states.
// Optional feature macro: I2D_WB_SLAVE_ERR_EN adds bus_err for misaligned/out-of-range addresses.
module wb_pl_mem_slave #(
   parameter int    ADDR_W      = 12,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_cyc,
   input  logic        bus_stb,
   input  logic        bus_we,
   input  logic [31:0] bus_adr,
   input  logic [3:0]  bus_sel,
   input  logic [31:0] bus_dat_ms,
   output logic [31:0] bus_dat_so,
   output logic        bus_ack,
`ifdef I2D_WB_SLAVE_ERR_EN
   output logic        bus_err,
`endif
   output logic        bus_stall
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK
   } state_t;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_INIT =
      4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   logic [31:0] mem [DEPTH];

   state_t state, state_nx;
   logic [3:0] cnt;

   logic [ADDR_W-1:0] l_idx;
   logic              l_we;
   logic [3:0]        l_sel;
   logic [31:0]       l_dat;
   logic              l_err;

   logic              accept;
   logic              access;
   logic [ADDR_W-1:0] a_idx;
   logic              a_we;
   logic [3:0]        a_sel;
   logic [31:0]       a_dat;
   logic              a_err;

   logic [ADDR_W-1:0] req_idx;
   logic              req_err;
   logic              ack_q;

   assign req_idx = bus_adr[ADDR_W+1:2];

`ifdef I2D_WB_SLAVE_ERR_EN
   logic err_q;
   assign req_err = (bus_adr[1:0] != 2'b00)
                  | (bus_adr[31:ADDR_W+2] != '0);
   assign bus_err = err_q;
`else
   logic unused_adr;
   assign unused_adr = ^{bus_adr[31:ADDR_W+2], bus_adr[1:0]};
   assign req_err    = 1'b0;
`endif

   assign bus_ack = ack_q;

   // With no wait states the live bus request is the access itself.
   always_comb begin
      state_nx  = state;
      bus_stall = 1'b0;
      accept    = 1'b0;
      access    = 1'b0;
      a_idx     = l_idx;
      a_we      = l_we;
      a_sel     = l_sel;
      a_dat     = l_dat;
      a_err     = l_err;
      if (WAIT_STATES == 0) begin
         accept = bus_cyc & bus_stb;
         access = accept;
         a_idx  = req_idx;
         a_we   = bus_we;
         a_sel  = bus_sel;
         a_dat  = bus_dat_ms;
         a_err  = req_err;
      end else begin
         bus_stall = (state == S_WAIT);
         accept    = bus_cyc & bus_stb & ~bus_stall;
         unique case (state)
            S_IDLE: begin
               if (accept) state_nx = S_WAIT;
            end
            S_WAIT: begin
               if (!bus_cyc) begin
                  state_nx = S_IDLE;
               end else if (cnt == 4'd0) begin
                  state_nx = S_ACK;
                  access   = 1'b1;
               end
            end
            S_ACK: begin
               state_nx = accept ? S_WAIT : S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         ack_q      <= 1'b0;
         bus_dat_so <= 32'd0;
         l_idx      <= '0;
         l_we       <= 1'b0;
         l_sel      <= 4'd0;
         l_dat      <= 32'd0;
         l_err      <= 1'b0;
      end else begin
         state <= state_nx;
         ack_q <= access & ~a_err;
         if (accept) begin
            l_idx <= req_idx;
            l_we  <= bus_we;
            l_sel <= bus_sel;
            l_dat <= bus_dat_ms;
            l_err <= req_err;
            cnt   <= CNT_INIT;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access && !a_we && !a_err) begin
            bus_dat_so <= mem[a_idx];
         end
      end
   end

`ifdef I2D_WB_SLAVE_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= access & a_err;
   end
`endif

   // Reset at the edge drops a write that has not yet committed.
   always_ff @(posedge clk) begin
      if (access && a_we && !a_err && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (a_sel[i]) mem[a_idx][8*i +: 8] <= a_dat[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_pl_mem_slave.sv
// Directed bench: zero-wait/wrap instance and a three-wait-state instance.
// Both share clock and reset; each has its own bus.
module tb_wb_pl_mem_slave;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        f_cyc, f_stb, f_we, f_ack, f_stall;
   logic [31:0] f_adr, f_dat, f_so;
   logic [3:0]  f_sel;
   logic        s_cyc, s_stb, s_we, s_ack, s_stall;
   logic [31:0] s_adr, s_dat, s_so;
   logic [3:0]  s_sel;
`ifdef I2D_WB_SLAVE_ERR_EN
   logic        f_err, s_err;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   wb_pl_mem_slave #(.ADDR_W(4), .WAIT_STATES(0)) u_fast (
      .clk        (clk),
      .rst        (rst),
      .bus_cyc    (f_cyc),
      .bus_stb    (f_stb),
      .bus_we     (f_we),
      .bus_adr    (f_adr),
      .bus_sel    (f_sel),
      .bus_dat_ms (f_dat),
      .bus_dat_so (f_so),
      .bus_ack    (f_ack),
`ifdef I2D_WB_SLAVE_ERR_EN
      .bus_err    (f_err),
`endif
      .bus_stall  (f_stall)
   );

   wb_pl_mem_slave #(.ADDR_W(12), .WAIT_STATES(3)) u_slow (
      .clk        (clk),
      .rst        (rst),
      .bus_cyc    (s_cyc),
      .bus_stb    (s_stb),
      .bus_we     (s_we),
      .bus_adr    (s_adr),
      .bus_sel    (s_sel),
      .bus_dat_ms (s_dat),
      .bus_dat_so (s_so),
      .bus_ack    (s_ack),
`ifdef I2D_WB_SLAVE_ERR_EN
      .bus_err    (s_err),
`endif
      .bus_stall  (s_stall)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic f_req(input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat);
      f_cyc = 1'b1;
      f_stb = 1'b1;
      f_we  = we;
      f_adr = adr;
      f_sel = sel;
      f_dat = dat;
      @(posedge clk);
      #1;
   endtask

   task automatic f_idle();
      f_cyc = 1'b0;
      f_stb = 1'b0;
      f_we  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic s_txn(input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output logic [31:0] so, output int lat,
                        output int stalls);
      int n;
      s_cyc = 1'b1;
      s_stb = 1'b1;
      s_we  = we;
      s_adr = adr;
      s_sel = sel;
      s_dat = dat;
      n = 0;
      while (s_stall && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      s_stb  = 1'b0;
      lat    = 1;
      stalls = 0;
      while (!s_ack && lat < 20) begin
         if (s_stall) stalls++;
         @(posedge clk);
         #1;
         lat++;
      end
      so    = s_so;
      s_cyc = 1'b0;
   endtask

   initial begin
      logic [31:0] so;
      int lat, st;
      logic any_ack;

      rst   = 1'b1;
      f_cyc = 0; f_stb = 0; f_we = 0; f_adr = 0; f_sel = 0; f_dat = 0;
      s_cyc = 0; s_stb = 0; s_we = 0; s_adr = 0; s_sel = 0; s_dat = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_f_ack",   {31'd0, f_ack},   32'd0);
      check("rst_f_stall", {31'd0, f_stall}, 32'd0);
      check("rst_f_so",    f_so,             32'd0);
      check("rst_s_ack",   {31'd0, s_ack},   32'd0);
      check("rst_s_stall", {31'd0, s_stall}, 32'd0);
      check("rst_s_so",    s_so,             32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // zero-wait instance: preload word k = k*0x11111111
      for (int k = 0; k < 16; k++) begin
         f_req(1'b1, 32'(k * 4), 4'hF, 32'(k) * 32'h1111_1111);
      end
      check("f_wr_ack", {31'd0, f_ack}, 32'd1);

      f_req(1'b0, 32'h0, 4'hF, 32'h0);
      check("f_rd0_ack",   {31'd0, f_ack},   32'd1);
      check("f_rd0_so",    f_so,             32'h0000_0000);
      check("f_rd0_stall", {31'd0, f_stall}, 32'd0);
      f_req(1'b0, 32'h4, 4'hF, 32'h0);
      check("f_rd1_ack",   {31'd0, f_ack},   32'd1);
      check("f_rd1_so",    f_so,             32'h1111_1111);
      check("f_rd1_stall", {31'd0, f_stall}, 32'd0);
      f_req(1'b0, 32'h8, 4'hF, 32'h0);
      check("f_rd2_ack",   {31'd0, f_ack},   32'd1);
      check("f_rd2_so",    f_so,             32'h2222_2222);
      f_idle();
      check("f_idle_ack", {31'd0, f_ack}, 32'd0);
      check("f_idle_so",  f_so,           32'h2222_2222);

      f_req(1'b1, 32'h10, 4'b0101, 32'hDEAD_BEEF);
      check("f_bw_ack", {31'd0, f_ack}, 32'd1);
      check("f_bw_so",  f_so,           32'h2222_2222);
      f_req(1'b0, 32'h10, 4'hF, 32'h0);
      check("f_bw_rd",  f_so,           32'h44AD_44EF);

      f_req(1'b1, 32'h14, 4'b0000, 32'hFFFF_FFFF);
      check("f_sel0_ack", {31'd0, f_ack}, 32'd1);
      f_req(1'b0, 32'h14, 4'hF, 32'h0);
      check("f_sel0_rd", f_so, 32'h5555_5555);

`ifdef I2D_WB_SLAVE_ERR_EN
      f_req(1'b0, 32'h0B, 4'hF, 32'h0);
      check("f_lowbit_err", {31'd0, f_err}, 32'd1);
      check("f_lowbit_ack", {31'd0, f_ack}, 32'd0);
      check("f_lowbit_so",  f_so,           32'h5555_5555);
      f_req(1'b0, 32'h40, 4'hF, 32'h0);
      check("f_wrap_err", {31'd0, f_err}, 32'd1);
      check("f_wrap_ack", {31'd0, f_ack}, 32'd0);
      check("f_wrap_so",  f_so,           32'h5555_5555);
      f_req(1'b1, 32'h44, 4'hF, 32'hCAFE_F00D);
      f_req(1'b0, 32'h4, 4'hF, 32'h0);
      check("f_wrap_wr", f_so, 32'h1111_1111);
`else
      f_req(1'b0, 32'h0B, 4'hF, 32'h0);
      check("f_lowbit_ack", {31'd0, f_ack}, 32'd1);
      check("f_lowbit_so",  f_so,           32'h2222_2222);
      f_req(1'b0, 32'h40, 4'hF, 32'h0);
      check("f_wrap_ack", {31'd0, f_ack}, 32'd1);
      check("f_wrap_so",  f_so,           32'h0000_0000);
      f_req(1'b1, 32'h44, 4'hF, 32'hCAFE_F00D);
      f_req(1'b0, 32'h4, 4'hF, 32'h0);
      check("f_wrap_wr", f_so, 32'hCAFE_F00D);
`endif

      f_cyc = 1'b0;
      f_stb = 1'b1;
      @(posedge clk);
      #1;
      check("f_nocyc_ack", {31'd0, f_ack}, 32'd0);
      f_idle();

      // three-wait-state instance
      s_txn(1'b1, 32'h8,  4'hF, 32'h2222_2222, so, lat, st);
      check("s_wr_lat", 32'(lat), 32'd4);
      s_txn(1'b1, 32'hC,  4'hF, 32'h3333_3333, so, lat, st);
      s_txn(1'b1, 32'h20, 4'hF, 32'h8888_8888, so, lat, st);
      s_txn(1'b0, 32'h8,  4'hF, 32'h0, so, lat, st);
      check("s_rd_lat",    32'(lat), 32'd4);
      check("s_rd_stalls", 32'(st),  32'd3);
      check("s_rd_so",     so,       32'h2222_2222);

      s_cyc = 1'b1;
      s_stb = 1'b1;
      s_we  = 1'b0;
      s_adr = 32'h8;
      @(posedge clk);
      #1;
      s_adr = 32'hC;
      for (int i = 0; i < 3; i++) begin
         check("s_pipe_stall", {31'd0, s_stall}, 32'd1);
         check("s_pipe_noack", {31'd0, s_ack},   32'd0);
         @(posedge clk);
         #1;
      end
      check("s_pipe_ack1",   {31'd0, s_ack},   32'd1);
      check("s_pipe_ackstl", {31'd0, s_stall}, 32'd0);
      check("s_pipe_so1",    s_so,             32'h2222_2222);
      @(posedge clk);
      #1;
      s_stb = 1'b0;
      check("s_pipe_acc2", {31'd0, s_stall}, 32'd1);
      check("s_pipe_ack0", {31'd0, s_ack},   32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("s_pipe_ack2", {31'd0, s_ack}, 32'd1);
      check("s_pipe_so2",  s_so,           32'h3333_3333);

      s_cyc = 1'b1;
      s_stb = 1'b1;
      s_we  = 1'b1;
      s_adr = 32'h20;
      s_sel = 4'hF;
      s_dat = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      any_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         any_ack = any_ack | s_ack;
         if (i == 0) check("s_abort_idle", {31'd0, s_stall}, 32'd0);
      end
      check("s_abort_noack", {31'd0, any_ack}, 32'd0);
      s_txn(1'b0, 32'h20, 4'hF, 32'h0, so, lat, st);
      check("s_abort_old", so, 32'h8888_8888);

      s_cyc = 1'b1;
      s_stb = 1'b1;
      s_we  = 1'b0;
      s_adr = 32'h8;
      @(posedge clk);
      #1;
      s_stb = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("s_rst_ack",   {31'd0, s_ack},   32'd0);
      check("s_rst_stall", {31'd0, s_stall}, 32'd0);
      check("s_rst_so",    s_so,             32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      s_cyc = 1'b0;
      @(posedge clk);
      #1;
      s_txn(1'b0, 32'h8, 4'hF, 32'h0, so, lat, st);
      check("s_post_lat", 32'(lat), 32'd4);
      check("s_post_so",  so,       32'h2222_2222);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
